// File: rtl/bcd_pkg.sv
// Shared constants and types for the digit-serial BCD add/subtract path.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_FIX = 4'd6;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic digit_bad(input logic [3:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with optional nine's complement of b and decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic       sub,
    output logic [3:0] s,
    output logic       co,
    output logic       bad
);

    logic [3:0] bd;
    logic [4:0] t;

    always_comb begin
        bd  = (sub == OP_SUB) ? (BCD_MAX - b) : b;
        t   = {1'b0, a} + {1'b0, bd} + {4'b0, ci};
        bad = digit_bad(a) || digit_bad(b);
        if (t > {1'b0, BCD_MAX}) begin
            // Only the low nibble survives, so 4-bit wraparound gives the corrected digit.
            s  = t[3:0] + BCD_FIX;
            co = 1'b1;
        end else begin
            s  = t[3:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial multi-digit BCD adder/subtractor, one digit per clock, LSD first.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    op,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     sum,
    output logic                    cout,
    output logic                    invalid
);

    localparam int unsigned W     = BCD_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             op_q, op_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             inv_q, inv_d;

    logic [3:0]       dig_s;
    logic             dig_co;
    logic             dig_bad;
    logic [W-1:0]     sum_shift;

    // Operands shift right each RUN cycle, so the current digit is always in the low nibble.
    bcd_digit_add u_digit (
        .a   (a_q[3:0]),
        .b   (b_q[3:0]),
        .ci  (carry_q),
        .sub (op_q),
        .s   (dig_s),
        .co  (dig_co),
        .bad (dig_bad)
    );

    // Result enters at the top and reaches its slot after DIGITS shifts.
    if (DIGITS == 1) begin : g_one
        assign sum_shift = dig_s;
    end else begin : g_multi
        assign sum_shift = {dig_s, sum_q[W-1:BCD_W]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        inv_d   = inv_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    carry_d = (op == OP_SUB) ? ~cin : cin;
                    idx_d   = '0;
                    inv_d   = 1'b0;
                    cout_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> BCD_W;
                b_d     = b_q >> BCD_W;
                carry_d = dig_co;
                sum_d   = sum_shift;
                inv_d   = inv_q | dig_bad;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST) begin
                    state_d = DONE;
                    idx_d   = '0;
                    if (inv_d) begin
                        sum_d  = '0;
                        cout_d = 1'b0;
                    end else begin
                        cout_d = dig_co;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            inv_q   <= inv_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign invalid = inv_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed self-checking bench for bcd_serial_addsub at DIGITS=4.
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        invalid;

    int total = 0;
    int bad   = 0;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 1;
        bcnt = 0;
        while (done !== 1'b1 && cyc <= 20) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic o, input logic [15:0] va,
                          input logic [15:0] vb, input logic vc, input logic [15:0] esum,
                          input logic ecout, input logic einv);
        int cyc;
        int bcnt;
        op    = o;
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bcnt);
        check({tag, ":lat"},  32'(cyc),  32'd5);
        check({tag, ":busy"}, 32'(bcnt), 32'd4);
        check({tag, ":sum"},  32'(sum),  32'(esum));
        check({tag, ":cout"}, 32'(cout), 32'(ecout));
        check({tag, ":inv"},  32'(invalid), 32'(einv));
        @(posedge clk);
        #1;
        check({tag, ":pulse"}, 32'(done), 32'd0);
        check({tag, ":hold"},  32'(sum),  32'(esum));
    endtask

    initial begin
        int cyc;
        int bcnt;
        int dcnt;
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_inv",  32'(invalid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("add",      1'b0, 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        run_op("chain",    1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("all9",     1'b0, 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
        run_op("sub_pos",  1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0);
        run_op("sub_neg",  1'b1, 16'h0003, 16'h0005, 1'b0, 16'h9998, 1'b0, 1'b0);
        run_op("sub_bin",  1'b1, 16'h1000, 16'h0001, 1'b1, 16'h0998, 1'b1, 1'b0);
        run_op("invalid",  1'b0, 16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
        run_op("add_cin",  1'b0, 16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0);

        // Second start during RUN must not disturb the latched operands.
        op = 1'b0; a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a = 16'h9999; b = 16'h9999; cin = 1'b1; op = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bcnt);
        check("ign:lat",  32'(cyc),  32'd3);
        check("ign:sum",  32'(sum),  32'h6912);
        check("ign:cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back: start held in the DONE cycle.
        op = 1'b1; a = 16'h0005; b = 16'h0003; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bcnt);
        check("b2b1:lat",  32'(cyc),  32'd5);
        check("b2b1:sum",  32'(sum),  32'h0002);
        op = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b2:done_drop", 32'(done), 32'd0);
        check("b2b2:busy_rise", 32'(busy), 32'd1);
        wait_done(cyc, bcnt);
        check("b2b2:lat",  32'(cyc),  32'd5);
        check("b2b2:sum",  32'(sum),  32'h3333);
        check("b2b2:cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the second RUN cycle aborts immediately.
        op = 1'b0; a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rrun:busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rrun:busy", 32'(busy), 32'd0);
        check("rrun:done", 32'(done), 32'd0);
        check("rrun:sum",  32'(sum),  32'd0);
        check("rrun:cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        check("rrun:no_done", 32'(dcnt), 32'd0);
        run_op("post_rst", 1'b0, 16'h4567, 16'h4444, 1'b0, 16'h9011, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
